// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-channel valid/ready multiplexer with fixed or round-robin
// selection feeding a single registered output stage.
module mux_rr_pipe #(
    parameter  int K = 24,
    parameter  int N = 4,
    localparam int S = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N*K-1:0] IN_DATA,
    input  logic [N-1:0]   IN_VALID,
    output logic [N-1:0]   IN_READY,
    input  logic           MODE,
    input  logic [S-1:0]   SEL,
    output logic [K-1:0]   O,
    output logic           O_VALID,
    input  logic           O_READY,
    output logic [S-1:0]   O_SRC
);
    logic [K-1:0] ch [N];
    logic [K-1:0] o_d, o_q;
    logic [S-1:0] src_d, src_q;
    logic [S-1:0] ptr_d, ptr_q;
    logic         o_valid_d, o_valid_q;
    logic         load;
    logic         gnt_vld;
    logic [S-1:0] gnt_idx;
    logic [S-1:0] cand;
    logic [N-1:0] in_ready;

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign ch[i] = IN_DATA[i*K +: K];
    end

    assign load = !o_valid_q || O_READY;

    // Round-robin search starts at ptr_q and wraps; the first valid channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!MODE) begin
            gnt_vld = (32'(SEL) < N) && IN_VALID[SEL];
            gnt_idx = SEL;
        end else begin
            for (int j = 0; j < N; j++) begin
                cand = S'((32'(ptr_q) + 32'(j)) % N);
                if (!gnt_vld && IN_VALID[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!RST && load && gnt_vld) in_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        o_d       = o_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        o_valid_d = o_valid_q;
        if (load) begin
            o_valid_d = gnt_vld;
            if (gnt_vld) begin
                o_d   = ch[gnt_idx];
                src_d = gnt_idx;
                if (MODE) ptr_d = (gnt_idx == S'(N - 1)) ? '0 : gnt_idx + S'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_q       <= '0;
            src_q     <= '0;
            ptr_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign IN_READY = in_ready;
    assign O        = o_q;
    assign O_SRC    = src_q;
    assign O_VALID  = o_valid_q;
endmodule
